// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write-back port and a
// per-register busy scoreboard for reserving destinations between issue and write-back.
module regfile_scoreboard #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     rs_addr,
   input  logic [ADDR_W-1:0]     rt_addr,
   output logic [DATA_W-1:0]     rs_data,
   output logic [DATA_W-1:0]     rt_data,
   output logic                  rs_ready,
   output logic                  rt_ready,
   input  logic                  issue_valid,
   input  logic [ADDR_W-1:0]     issue_dst,
   output logic                  issue_ready,
   input  logic                  wb_valid,
   input  logic [ADDR_W-1:0]     wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   output logic [2**ADDR_W-1:0]  busy_vec,
   output logic [ADDR_W:0]       pending_cnt,
   output logic                  wb_err
);
   localparam int NREGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs_reg [NREGS];
   logic [NREGS-1:0]  busy_reg, busy_next;
   logic [ADDR_W:0]   pending_reg, pending_next;
   logic              wb_err_reg, wb_err_next;
   logic              wb_zero, issue_zero, wb_en, issue_en;

   assign wb_zero    = (ZERO_REG != 0) && (wb_addr == '0);
   assign issue_zero = (ZERO_REG != 0) && (issue_dst == '0);
   assign wb_en      = wb_valid && !wb_zero;

   // A write-back in the same cycle deliberately does not free the slot for a new issue.
   assign issue_ready = issue_zero ? 1'b1 : !busy_reg[issue_dst];
   assign issue_en    = issue_valid && issue_ready && !issue_zero;

   // Returns {ready, data} for one read port.
   function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
      if ((ZERO_REG != 0) && (a == '0))
         return {1'b1, {DATA_W{1'b0}}};
      else if ((BYPASS != 0) && wb_en && (wb_addr == a))
         return {1'b1, wb_data};
      else
         return {!busy_reg[a], regs_reg[a]};
   endfunction

   assign {rs_ready, rs_data} = read_port(rs_addr);
   assign {rt_ready, rt_data} = read_port(rt_addr);

   always_comb begin
      busy_next = busy_reg;
      if (wb_en)
         busy_next[wb_addr] = 1'b0;
      if (issue_en)
         busy_next[issue_dst] = 1'b1;
   end

   always_comb begin
      pending_next = '0;
      for (int i = 0; i < NREGS; i++)
         pending_next = pending_next + {{ADDR_W{1'b0}}, busy_next[i]};
   end

   assign wb_err_next = wb_err_reg | (wb_en & !busy_reg[wb_addr]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_reg    <= '0;
         pending_reg <= '0;
         wb_err_reg  <= 1'b0;
      end else begin
         busy_reg    <= busy_next;
         pending_reg <= pending_next;
         wb_err_reg  <= wb_err_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               regs_reg[gi] <= '0;
            else if (wb_en && (wb_addr == ADDR_W'(gi)))
               regs_reg[gi] <= wb_data;
         end
      end
   endgenerate

   assign busy_vec    = busy_reg;
   assign pending_cnt = pending_reg;
   assign wb_err      = wb_err_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_scoreboard;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rs_addr, rt_addr, issue_dst, wb_addr;
   logic [7:0]  rs_data, rt_data, wb_data;
   logic        rs_ready, rt_ready, issue_valid, issue_ready, wb_valid, wb_err;
   logic [7:0]  busy_vec;
   logic [3:0]  pending_cnt;

   localparam int S_RS_DATA = 0, S_RT_DATA = 1, S_RS_RDY = 2, S_RT_RDY = 3;
   localparam int S_ISS_RDY = 4, S_BUSY = 5, S_PEND = 6, S_ERR = 7;

   typedef struct {
      string       name;
      int          sig;
      logic [15:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;

   regfile_scoreboard #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .rst(rst),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data), .rt_data(rt_data),
      .rs_ready(rs_ready), .rt_ready(rt_ready),
      .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .busy_vec(busy_vec), .pending_cnt(pending_cnt), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] sample(input int s);
      case (s)
         S_RS_DATA: return 16'(rs_data);
         S_RT_DATA: return 16'(rt_data);
         S_RS_RDY:  return 16'(rs_ready);
         S_RT_RDY:  return 16'(rt_ready);
         S_ISS_RDY: return 16'(issue_ready);
         S_BUSY:    return 16'(busy_vec);
         S_PEND:    return 16'(pending_cnt);
         default:   return 16'(wb_err);
      endcase
   endfunction

   task automatic push_exp(input string n, input int s, input logic [15:0] e);
      exp_t x;
      x.name = n;
      x.sig  = s;
      x.exp  = e;
      exp_q.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: everything queued during the current cycle is checked mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            exp_t x;
            logic [15:0] got;
            x = exp_q.pop_front();
            got = sample(x.sig);
            compared++;
            if (got !== x.exp) begin
               mismatched++;
               $display("FAIL %s: got %0h expected %0h", x.name, got, x.exp);
            end else begin
               $display("ok   %s: %0h", x.name, got);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      rs_addr = '0; rt_addr = '0; issue_valid = 1'b0; issue_dst = '0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state on every index
      for (int a = 0; a < 8; a++) begin
         rs_addr = 3'(a); rt_addr = 3'(7 - a); issue_dst = 3'(a);
         push_exp("rst_rs_data", S_RS_DATA, 16'h0);
         push_exp("rst_rt_data", S_RT_DATA, 16'h0);
         push_exp("rst_rs_rdy", S_RS_RDY, 16'h1);
         push_exp("rst_rt_rdy", S_RT_RDY, 16'h1);
         push_exp("rst_iss_rdy", S_ISS_RDY, 16'h1);
         if (a == 0) begin
            push_exp("rst_busy", S_BUSY, 16'h0);
            push_exp("rst_pend", S_PEND, 16'h0);
            push_exp("rst_err", S_ERR, 16'h0);
         end
         step();
      end

      // Issue r3, then bypassed write-back
      issue_valid = 1'b1; issue_dst = 3'd3;
      push_exp("t2_iss_rdy", S_ISS_RDY, 16'h1);
      step();
      issue_valid = 1'b0; rs_addr = 3'd3; rt_addr = 3'd3;
      push_exp("t2_busy", S_BUSY, 16'h08);
      push_exp("t2_rt_rdy_busy", S_RT_RDY, 16'h0);
      push_exp("t2_rs_rdy_busy", S_RS_RDY, 16'h0);
      push_exp("t2_pend1", S_PEND, 16'h1);
      step();
      wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 8'hA5;
      push_exp("t2_bypass_data", S_RT_DATA, 16'hA5);
      push_exp("t2_bypass_rdy", S_RT_RDY, 16'h1);
      step();
      wb_valid = 1'b0;
      push_exp("t2_busy_clr", S_BUSY, 16'h0);
      push_exp("t2_pend0", S_PEND, 16'h0);
      push_exp("t2_stored", S_RT_DATA, 16'hA5);
      push_exp("t2_err", S_ERR, 16'h0);
      step();

      // WAW blocked while a same-cycle write-back retires r3
      issue_valid = 1'b1; issue_dst = 3'd3;
      step();
      wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 8'h5A;
      push_exp("t3_iss_blocked", S_ISS_RDY, 16'h0);
      push_exp("t3_busy", S_BUSY, 16'h08);
      step();
      issue_valid = 1'b0; wb_valid = 1'b0; rs_addr = 3'd3;
      push_exp("t3_busy_clr", S_BUSY, 16'h0);
      push_exp("t3_reg3", S_RS_DATA, 16'h5A);
      push_exp("t3_rdy", S_RS_RDY, 16'h1);
      push_exp("t3_err", S_ERR, 16'h0);
      push_exp("t3_pend", S_PEND, 16'h0);
      step();

      // Zero register ignores write-back and reservation
      wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 8'hFF;
      issue_valid = 1'b1; issue_dst = 3'd0; rs_addr = 3'd0;
      push_exp("t4_iss_rdy0", S_ISS_RDY, 16'h1);
      push_exp("t4_rs0_wb", S_RS_DATA, 16'h0);
      push_exp("t4_rs0_rdy", S_RS_RDY, 16'h1);
      step();
      wb_valid = 1'b0; issue_valid = 1'b0;
      push_exp("t4_rs0", S_RS_DATA, 16'h0);
      push_exp("t4_busy", S_BUSY, 16'h0);
      push_exp("t4_err", S_ERR, 16'h0);
      push_exp("t4_pend", S_PEND, 16'h0);
      step();

      // Write-back to an idle register sets the sticky error
      wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 8'h11;
      step();
      wb_valid = 1'b0; rs_addr = 3'd5;
      push_exp("t5_reg5", S_RS_DATA, 16'h11);
      push_exp("t5_err_set", S_ERR, 16'h1);
      step();
      issue_valid = 1'b1; issue_dst = 3'd2;
      step();
      issue_valid = 1'b0; wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 8'h22;
      step();
      wb_valid = 1'b0; rt_addr = 3'd2;
      push_exp("t5_err_sticky", S_ERR, 16'h1);
      push_exp("t5_busy", S_BUSY, 16'h0);
      push_exp("t5_reg2", S_RT_DATA, 16'h22);
      step();

      // Reservations interrupted by an asynchronous reset
      for (int k = 1; k <= 3; k++) begin
         issue_valid = 1'b1; issue_dst = 3'(k);
         push_exp("t6a_pend", S_PEND, 16'(k - 1));
         push_exp("t6a_iss_rdy", S_ISS_RDY, 16'h1);
         step();
      end
      issue_valid = 1'b0;
      rst = 1'b1; rs_addr = 3'd5; rt_addr = 3'd1;
      push_exp("t6_rst_pend", S_PEND, 16'h0);
      push_exp("t6_rst_busy", S_BUSY, 16'h0);
      push_exp("t6_rst_err", S_ERR, 16'h0);
      push_exp("t6_rst_reg5", S_RS_DATA, 16'h0);
      push_exp("t6_rst_rdy1", S_RT_RDY, 16'h1);
      step();
      rst = 1'b0;
      step();

      // Fill r1..r7
      for (int k = 1; k <= 7; k++) begin
         issue_valid = 1'b1; issue_dst = 3'(k);
         push_exp("t6b_pend", S_PEND, 16'(k - 1));
         step();
      end
      issue_valid = 1'b0; issue_dst = 3'd4; rs_addr = 3'd4; rt_addr = 3'd0;
      push_exp("t6b_pend7", S_PEND, 16'h7);
      push_exp("t6b_busy", S_BUSY, 16'hFE);
      push_exp("t6b_iss_full", S_ISS_RDY, 16'h0);
      push_exp("t6b_rs4_rdy", S_RS_RDY, 16'h0);
      push_exp("t6b_rt0_rdy", S_RT_RDY, 16'h1);
      step();

      // Bounded drain of the scoreboard queue
      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         step();
      if (exp_q.size() > 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
